// File: rtl/dsp_seq_pkg.sv
// Shared types and defaults for the DSP frame sequencer.
// Optional overrun counter width lives here too (used when SEQ_OVERRUN_COUNT_EN is defined).
package dsp_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      RUN     = 2'd2,
      CAPTURE = 2'd3
   } seq_state_t;

   localparam int DEF_N_CHAN     = 8;
   localparam int DEF_DATA_W     = 36;
   localparam int DEF_RUN_CYCLES = 25;
   localparam int OVR_CNT_W      = 16;

   // Saturating increment for the overrun counter.
   function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
      logic [OVR_CNT_W-1:0] r;
      if (v == {OVR_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_pending_slot.sv
// One-entry frame buffer; a read and write together while full replaces the entry.
module seq_pending_slot #(
   parameter int W = 288
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic [W-1:0] wdata,
   input  logic         rd,
   output logic [W-1:0] rdata,
   output logic         full
);

   logic [W-1:0] data_q, data_d;
   logic         full_q, full_d;

   // Next entry contents and occupancy.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (wr) begin
         data_d = wdata;
         full_d = 1'b1;
      end else if (rd) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   // Slot registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= {W{1'b0}};
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign rdata = data_q;
   assign full  = full_q;

endmodule

// File: rtl/dsp_frame_sequencer.sv
// Frame controller feeding DSPCore: latch frame, pulse start, wait RUN_CYCLES, capture result.
// Define SEQ_OVERRUN_COUNT_EN to add the saturating overrun_count output.
module dsp_frame_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int N_CHAN     = DEF_N_CHAN,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RUN_CYCLES = DEF_RUN_CYCLES,
   parameter int FCNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_valid,
   input  logic [N_CHAN*DATA_W-1:0] in_data,
   output logic                     core_start,
   output logic [N_CHAN*DATA_W-1:0] core_inputs,
   input  logic [N_CHAN*DATA_W-1:0] core_outputs,
   output logic                     out_valid,
   output logic [N_CHAN*DATA_W-1:0] out_data,
   output logic                     busy,
   output logic                     overrun,
`ifdef SEQ_OVERRUN_COUNT_EN
   output logic [OVR_CNT_W-1:0]     overrun_count,
`endif
   output logic [FCNT_W-1:0]        frame_count
);

   localparam int W      = N_CHAN * DATA_W;
   localparam int RCNT_W = 16;

   seq_state_t         state_q, state_d;
   logic [RCNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic [W-1:0]       core_inputs_q, core_inputs_d;
   logic [W-1:0]       out_data_q, out_data_d;
   logic               core_start_q, core_start_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;
   logic [FCNT_W-1:0]  frame_count_q, frame_count_d;
   logic               slot_wr_s, slot_rd_s, slot_full_s, drop_s;
   logic [W-1:0]       slot_rdata_s;

   seq_pending_slot #(.W(W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .wr    (slot_wr_s),
      .wdata (in_data),
      .rd    (slot_rd_s),
      .rdata (slot_rdata_s),
      .full  (slot_full_s)
   );

   // Pending-slot control: store or drop while running, hand over at capture.
   always_comb begin
      slot_wr_s = 1'b0;
      slot_rd_s = 1'b0;
      drop_s    = 1'b0;
      if (state_q == CAPTURE) begin
         slot_rd_s = slot_full_s;
         slot_wr_s = sample_valid & slot_full_s;
      end else if ((state_q == START) || (state_q == RUN)) begin
         slot_wr_s = sample_valid & ~slot_full_s;
         drop_s    = sample_valid & slot_full_s;
      end else begin
         drop_s    = 1'b0;
      end
   end

   // Sequencer state machine and datapath next-state.
   always_comb begin
      state_d       = state_q;
      run_cnt_d     = run_cnt_q;
      core_inputs_d = core_inputs_q;
      out_data_d    = out_data_q;
      frame_count_d = frame_count_q;
      case (state_q)
         IDLE: begin
            if (sample_valid) begin
               state_d       = START;
               core_inputs_d = in_data;
            end else begin
               state_d       = IDLE;
            end
         end
         START: begin
            run_cnt_d = RCNT_W'(RUN_CYCLES - 1);
            state_d   = RUN;
         end
         RUN: begin
            if (run_cnt_q == {RCNT_W{1'b0}}) begin
               state_d   = CAPTURE;
            end else begin
               run_cnt_d = run_cnt_q - {{(RCNT_W-1){1'b0}}, 1'b1};
            end
         end
         CAPTURE: begin
            out_data_d    = core_outputs;
            frame_count_d = frame_count_q + {{(FCNT_W-1){1'b0}}, 1'b1};
            // A buffered frame takes priority over a frame arriving this cycle.
            if (slot_full_s) begin
               core_inputs_d = slot_rdata_s;
               state_d       = START;
            end else if (sample_valid) begin
               core_inputs_d = in_data;
               state_d       = START;
            end else begin
               state_d       = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      core_start_d = (state_d == START);
      busy_d       = (state_d != IDLE);
      out_valid_d  = (state_q == CAPTURE);
      overrun_d    = drop_s;
   end

   // Sequencer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         run_cnt_q     <= {RCNT_W{1'b0}};
         core_inputs_q <= {W{1'b0}};
         out_data_q    <= {W{1'b0}};
         core_start_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         frame_count_q <= {FCNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         run_cnt_q     <= run_cnt_d;
         core_inputs_q <= core_inputs_d;
         out_data_q    <= out_data_d;
         core_start_q  <= core_start_d;
         out_valid_q   <= out_valid_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         frame_count_q <= frame_count_d;
      end
   end

`ifdef SEQ_OVERRUN_COUNT_EN
   logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

   // Overrun counter next value; saturates.
   always_comb begin
      if (drop_s) begin
         ovr_cnt_d = sat_inc(ovr_cnt_q);
      end else begin
         ovr_cnt_d = ovr_cnt_q;
      end
   end

   // Overrun counter register, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr_cnt_q <= {OVR_CNT_W{1'b0}};
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_count = ovr_cnt_q;
`endif

   assign core_start  = core_start_q;
   assign core_inputs = core_inputs_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// Scoreboard bench for dsp_frame_sequencer: default build plus a FCNT_W=4, RUN_CYCLES=1 instance.
module tb_dsp_frame_sequencer;

   localparam int NC = 8;
   localparam int DW = 36;
   localparam int W  = NC * DW;
   localparam int R  = 25;
   localparam logic [W-1:0] MASK = {NC{36'h5A5AA5A53}};

   logic         clk = 1'b0;
   logic         rst;
   logic         sv, sv2;
   logic [W-1:0] in_data, in2;
   logic         core_start, out_valid, busy, overrun;
   logic [W-1:0] core_inputs, core_outputs, out_data;
   logic [15:0]  frame_count;
   logic         cs2, ov2, busy2, ovr2;
   logic [W-1:0] cin2, cout2, od2;
   logic [3:0]   fc2;
`ifdef SEQ_OVERRUN_COUNT_EN
   logic [15:0]  overrun_count, overrun_count2;
`endif

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp2_q[$];

   always #5 clk = ~clk;

   // Core model: result is the input frame XORed with a fixed pattern.
   assign core_outputs = core_inputs ^ MASK;
   assign cout2        = cin2 ^ MASK;

   dsp_frame_sequencer #(.N_CHAN(NC), .DATA_W(DW), .RUN_CYCLES(R), .FCNT_W(16)) dut (
      .clk(clk), .reset(rst), .sample_valid(sv), .in_data(in_data),
      .core_start(core_start), .core_inputs(core_inputs), .core_outputs(core_outputs),
      .out_valid(out_valid), .out_data(out_data), .busy(busy), .overrun(overrun),
`ifdef SEQ_OVERRUN_COUNT_EN
      .overrun_count(overrun_count),
`endif
      .frame_count(frame_count)
   );

   dsp_frame_sequencer #(.N_CHAN(NC), .DATA_W(DW), .RUN_CYCLES(1), .FCNT_W(4)) dut2 (
      .clk(clk), .reset(rst), .sample_valid(sv2), .in_data(in2),
      .core_start(cs2), .core_inputs(cin2), .core_outputs(cout2),
      .out_valid(ov2), .out_data(od2), .busy(busy2), .overrun(ovr2),
`ifdef SEQ_OVERRUN_COUNT_EN
      .overrun_count(overrun_count2),
`endif
      .frame_count(fc2)
   );

   // Scoreboard monitors: every out_valid pops one expected frame.
   always @(negedge clk) begin
      if (out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_data_unexpected: out_valid with empty scoreboard, got %h", out_data);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_data: got %h required %h", out_data, e);
            end
         end
      end
      if (ov2) begin
         checks++;
         if (exp2_q.size() == 0) begin
            errors++;
            $display("FAIL out_data2_unexpected: got %h", od2);
         end else begin
            logic [W-1:0] e2;
            e2 = exp2_q.pop_front();
            if (od2 !== e2) begin
               errors++;
               $display("FAIL out_data2: got %h required %h", od2, e2);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_frame();
      logic [W-1:0] f;
      for (int i = 0; i < W; i += 32) f[i +: 32] = $urandom();
      return f;
   endfunction

   task automatic drain;
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", busy, n);
      end
      tick();
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; sv = 1'b0; sv2 = 1'b0; in_data = '0; in2 = '0;
      tick(); tick();
      checks++;
      if ({core_start, out_valid, busy, overrun} !== 4'b0000 || core_inputs !== '0 ||
          out_data !== '0 || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: cs=%b ov=%b busy=%b ovr=%b fc=%0d, required all 0",
                  core_start, out_valid, busy, overrun, frame_count);
      end
      rst = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b cs=%b required 0 0", busy, core_start);
      end
   endtask

   task automatic test_single_frame;
      logic [W-1:0] f;
      f = '0;
      f[35:0] = 36'h400;
      in_data = f; sv = 1'b1; exp_q.push_back(f ^ MASK);
      tick();
      sv = 1'b0; in_data = '0;
      checks++;
      if (core_start !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_start: cs=%b busy=%b required 1 1", core_start, busy);
      end
      checks++;
      if (core_inputs !== f) begin
         errors++;
         $display("FAIL single_core_inputs: got %h required %h", core_inputs, f);
      end
      for (int c = 2; c <= R + 2; c++) begin
         tick();
         checks++;
         if (busy !== 1'b1 || core_start !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_run c=%0d: busy=%b cs=%b ov=%b required 1 0 0", c, busy, core_start, out_valid);
         end
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd1) begin
         errors++;
         $display("FAIL single_done: ov=%b busy=%b fc=%0d required 1 0 1", out_valid, busy, frame_count);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse: ov=%b required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      int ovr_seen = 0;
      logic [W-1:0] f;
      for (int k = 0; k < 10; k++) begin
         f = rand_frame();
         in_data = f; sv = 1'b1; exp_q.push_back(f ^ MASK);
         tick();
         sv = 1'b0;
         if (overrun === 1'b1) ovr_seen++;
         checks++;
         if (core_start !== 1'b1 || core_inputs !== f) begin
            errors++;
            $display("FAIL b2b_start k=%0d: cs=%b inputs=%h required 1 %h", k, core_start, core_inputs, f);
         end
         for (int c = 2; c <= R + 2; c++) begin
            tick();
            if (overrun === 1'b1) ovr_seen++;
            checks++;
            if (core_start !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_gap k=%0d c=%0d: cs=%b busy=%b required 0 1", k, c, core_start, busy);
            end
         end
      end
      drain();
      checks++;
      if (ovr_seen != 0 || frame_count !== 16'd11) begin
         errors++;
         $display("FAIL b2b_summary: overruns=%0d fc=%0d required 0 11", ovr_seen, frame_count);
      end
   endtask

   task automatic test_overrun;
      logic [W-1:0] a, b;
      a = rand_frame(); b = rand_frame();
      in_data = a; sv = 1'b1; exp_q.push_back(a ^ MASK);
      for (int c = 1; c <= R + 3; c++) begin
         tick();
         checks++;
         if (overrun !== ((c == 5) || (c == 7)) || core_start !== ((c == 1) || (c == 28))) begin
            errors++;
            $display("FAIL overrun_seq c=%0d: ovr=%b cs=%b", c, overrun, core_start);
         end
         if (c == 28) begin
            checks++;
            if (core_inputs !== b) begin
               errors++;
               $display("FAIL overrun_slot_frame: got %h required %h", core_inputs, b);
            end
         end
         sv = (c == 2) || (c == 4) || (c == 6);
         if (c == 2) begin
            in_data = b;
            exp_q.push_back(b ^ MASK);
         end else begin
            in_data = rand_frame();
         end
      end
      sv = 1'b0;
      drain();
      checks++;
      if (frame_count !== 16'd13) begin
         errors++;
         $display("FAIL overrun_fc: got %0d required 13", frame_count);
      end
`ifdef SEQ_OVERRUN_COUNT_EN
      checks++;
      if (overrun_count !== 16'd2) begin
         errors++;
         $display("FAIL overrun_count: got %0d required 2", overrun_count);
      end
`endif
   endtask

   task automatic test_capture_bypass;
      logic [W-1:0] a, b;
      a = rand_frame(); b = rand_frame();
      in_data = a; sv = 1'b1; exp_q.push_back(a ^ MASK);
      tick();
      sv = 1'b0;
      for (int c = 2; c <= R + 2; c++) tick();
      in_data = b; sv = 1'b1; exp_q.push_back(b ^ MASK);
      tick();
      sv = 1'b0;
      checks++;
      if (core_start !== 1'b1 || busy !== 1'b1 || core_inputs !== b || overrun !== 1'b0) begin
         errors++;
         $display("FAIL bypass: cs=%b busy=%b ovr=%b inputs=%h required 1 1 0 %h",
                  core_start, busy, overrun, core_inputs, b);
      end
      drain();
      checks++;
      if (frame_count !== 16'd15) begin
         errors++;
         $display("FAIL bypass_fc: got %0d required 15", frame_count);
      end
   endtask

   task automatic test_reset_mid_run;
      logic [W-1:0] a;
      a = rand_frame();
      in_data = a; sv = 1'b1;
      tick();
      sv = 1'b0;
      for (int c = 2; c <= 14; c++) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_busy: got %b required 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({core_start, out_valid, busy, overrun} !== 4'b0000 || core_inputs !== '0 ||
          out_data !== '0 || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL midrun_reset: cs=%b ov=%b busy=%b ovr=%b fc=%0d required all 0",
                  core_start, out_valid, busy, overrun, frame_count);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 30; c++) tick();
`ifdef SEQ_OVERRUN_COUNT_EN
      checks++;
      if (overrun_count !== 16'd0) begin
         errors++;
         $display("FAIL midrun_ovr_count: got %0d required 0", overrun_count);
      end
`endif
      a = rand_frame();
      in_data = a; sv = 1'b1; exp_q.push_back(a ^ MASK);
      tick();
      sv = 1'b0;
      checks++;
      if (core_start !== 1'b1) begin
         errors++;
         $display("FAIL midrun_restart: cs=%b required 1", core_start);
      end
      for (int c = 2; c <= R + 2; c++) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrun_early: ov=%b required 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || frame_count !== 16'd1) begin
         errors++;
         $display("FAIL midrun_latency: ov=%b fc=%0d required 1 1", out_valid, frame_count);
      end
      drain();
   endtask

   task automatic test_wrap_small;
      logic [W-1:0] f;
      for (int k = 0; k < 17; k++) begin
         f = rand_frame();
         in2 = f; sv2 = 1'b1; exp2_q.push_back(f ^ MASK);
         tick();
         sv2 = 1'b0;
         checks++;
         if (cs2 !== 1'b1 || ov2 !== (k != 0)) begin
            errors++;
            $display("FAIL wrap_start k=%0d: cs=%b ov=%b", k, cs2, ov2);
         end
         if (k == 16) begin
            checks++;
            if (fc2 !== 4'd0) begin
               errors++;
               $display("FAIL wrap_zero: fc=%0d required 0", fc2);
            end
         end
         tick();
         tick();
      end
      tick();
      checks++;
      if (ov2 !== 1'b1 || fc2 !== 4'd1) begin
         errors++;
         $display("FAIL wrap_final: ov=%b fc=%0d required 1 1", ov2, fc2);
      end
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overrun();
      test_capture_bypass();
      test_reset_mid_run();
      test_wrap_small();
      checks++;
      if (exp_q.size() != 0 || exp2_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d and %0d frames never produced", exp_q.size(), exp2_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
